uart_mem_loader: RTL



---
 rtl/uart_mem_loader.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/uart_mem_loader.sv
// uart_mem_loader: target-side responder for the host load/inspect protocol.
// Decodes WRITE/READ/RUN commands from the RX byte stream, drives the RAM port and queues replies to TX.
module uart_mem_loader #(
  parameter int unsigned TIMEOUT_CYCLES = 60000000,
  parameter int unsigned READ_LAT       = 2,
  parameter int unsigned ADDR_W         = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_wr,
  input  logic              tx_full,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic              ram_we,
  input  logic [31:0]       ram_rdata,
  output logic              core_ena,
  output logic              busy,
  output logic              err
);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned LW = $clog2(READ_LAT + 2);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR_H, S_ADDR_L, S_COUNT, S_WDATA, S_WR_MEM,
    S_ACK, S_ERR_TX, S_RD_REQ, S_RD_SEND, S_RUN
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [4:0]        hi_q, hi_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              rd_q, rd_d;
  logic [1:0]        bidx_q, bidx_d;
  logic [23:0]       wsh_q, wsh_d;
  logic [7:0]        csum_q, csum_d;
  logic [31:0]       rdbuf_q, rdbuf_d;
  logic [7:0]        txd_q, txd_d;
  logic              pend_q, pend_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              run_q, run_d;
  logic              busy_q;
  logic              err_q, err_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [LW-1:0]     lat_q, lat_d;
  logic              timed;

  // The pending byte and its data are registered; the write strobe is masked by tx_full
  // in the same cycle so a FIFO that fills unexpectedly is never written.
  assign tx_wr     = pend_q & ~tx_full;
  assign tx_data   = txd_q;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign ram_we    = we_q;
  assign core_ena  = run_q;
  assign busy      = busy_q;
  assign err       = err_q;

  assign timed = (state_q == S_ADDR_H) || (state_q == S_ADDR_L) ||
                 (state_q == S_COUNT)  || (state_q == S_WDATA);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    hi_d    = hi_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    bidx_d  = bidx_q;
    wsh_d   = wsh_q;
    csum_d  = csum_q;
    rdbuf_d = rdbuf_q;
    txd_d   = txd_q;
    pend_d  = pend_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    run_d   = 1'b0;
    err_d   = err_q;
    tmo_d   = '0;
    lat_d   = lat_q;

    unique case (state_q)
      S_IDLE: if (rx_valid) begin
        unique case (rx_data)
          8'h01, 8'h02: begin
            rd_d    = rx_data[1];
            csum_d  = '0;
            state_d = S_ADDR_H;
          end
          8'hFF: begin
            run_d   = 1'b1;
            state_d = S_RUN;
          end
          default: begin
            txd_d   = 8'hEE;
            pend_d  = 1'b1;
            err_d   = 1'b1;
            state_d = S_ERR_TX;
          end
        endcase
      end
      S_ADDR_H: if (rx_valid) begin
        hi_d    = rx_data[4:0];
        state_d = S_ADDR_L;
      end
      S_ADDR_L: if (rx_valid) begin
        addr_d  = ADDR_W'({hi_q, rx_data});
        state_d = S_COUNT;
      end
      S_COUNT: if (rx_valid) begin
        cnt_d   = rx_data;
        bidx_d  = '0;
        lat_d   = '0;
        state_d = rd_q ? S_RD_REQ : S_WDATA;
      end
      S_WDATA: if (rx_valid) begin
        csum_d = csum_q + rx_data;
        wsh_d  = {wsh_q[15:0], rx_data};
        bidx_d = bidx_q + 2'd1;
        if (bidx_q == 2'd3) begin
          wdata_d = {wsh_q, rx_data};
          we_d    = 1'b1;
          state_d = S_WR_MEM;
        end
      end
      S_WR_MEM: begin
        addr_d = addr_q + ADDR_W'(1);
        cnt_d  = cnt_q - 8'd1;
        // A count of 1 is the last word; N=0 counts down through 255..1 giving 256 words.
        if (cnt_q == 8'd1) begin
          txd_d   = csum_q;
          pend_d  = 1'b1;
          state_d = S_ACK;
        end else begin
          state_d = S_WDATA;
        end
      end
      S_ACK, S_ERR_TX: if (tx_wr) begin
        pend_d  = 1'b0;
        state_d = S_IDLE;
      end
      S_RD_REQ: begin
        if (lat_q == LW'(READ_LAT)) begin
          rdbuf_d = ram_rdata;
          txd_d   = ram_rdata[31:24];
          pend_d  = 1'b1;
          bidx_d  = '0;
          state_d = S_RD_SEND;
        end else begin
          lat_d = lat_q + LW'(1);
        end
      end
      S_RD_SEND: if (tx_wr) begin
        if (bidx_q == 2'd3) begin
          pend_d  = 1'b0;
          addr_d  = addr_q + ADDR_W'(1);
          cnt_d   = cnt_q - 8'd1;
          lat_d   = '0;
          state_d = (cnt_q == 8'd1) ? S_IDLE : S_RD_REQ;
        end else begin
          bidx_d  = bidx_q + 2'd1;
          txd_d   = rdbuf_q[23:16];
          rdbuf_d = {rdbuf_q[23:0], 8'h00};
        end
      end
      S_RUN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // An arriving byte always beats expiry and restarts the idle count.
    if (timed && !rx_valid) begin
      if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
        err_d   = 1'b1;
        state_d = S_IDLE;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      hi_q    <= '0;
      cnt_q   <= '0;
      rd_q    <= 1'b0;
      bidx_q  <= '0;
      wsh_q   <= '0;
      csum_q  <= '0;
      rdbuf_q <= '0;
      txd_q   <= '0;
      pend_q  <= 1'b0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      run_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      tmo_q   <= '0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      hi_q    <= hi_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      bidx_q  <= bidx_d;
      wsh_q   <= wsh_d;
      csum_q  <= csum_d;
      rdbuf_q <= rdbuf_d;
      txd_q   <= txd_d;
      pend_q  <= pend_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      run_q   <= run_d;
      busy_q  <= (state_d != S_IDLE);
      err_q   <= err_d;
      tmo_q   <= tmo_d;
      lat_q   <= lat_d;
    end
  end

endmodule
